// File: rtl/bp_be_calc_status_tracker.sv
// Issue-to-retire status tracker for a short calculator pipe: ISD slot, three EX stages,
// expected next-PC tracking and a retired-instruction counter.
module bp_be_calc_status_tracker (
    input  logic        clk_i,
    input  logic        reset_i,

    input  logic        issue_v_i,
    output logic        issue_ready_o,
    input  logic [63:0] issue_pc_i,
    input  logic [4:0]  issue_rd_addr_i,
    input  logic        issue_irf_w_v_i,
    input  logic        issue_frf_w_v_i,

    input  logic        chk_dispatch_v_i,
    input  logic        chk_poison_isd_i,
    input  logic        chk_poison_ex_i,
    input  logic        chk_roll_i,

    input  logic        ex1_br_taken_i,
    input  logic [63:0] ex1_br_tgt_i,

    output logic [2:0]  stage_v_o,
    output logic [14:0] stage_rd_addr_o,
    output logic [2:0]  stage_irf_w_v_o,
    output logic [2:0]  stage_frf_w_v_o,

    output logic        isd_v_o,
    output logic [63:0] isd_pc_o,
    output logic [4:0]  isd_rd_addr_o,

    output logic        expected_npc_v_o,
    output logic [63:0] expected_npc_o,
    output logic [31:0] retire_cnt_o
);

    localparam int STAGES = 3;

    typedef struct packed {
        logic        v;
        logic [63:0] pc;
        logic [4:0]  rd;
        logic        irf;
        logic        frf;
    } entry_t;

    entry_t                isd_q, isd_d;
    entry_t [STAGES-1:0]   ex_q, ex_d;
    logic                  npc_v_q, npc_v_d;
    logic [63:0]           npc_q, npc_d;
    logic [31:0]           retire_cnt_q, retire_cnt_d;

    logic issue_fire;
    logic ex1_go;

    assign issue_ready_o = ~chk_roll_i & (~isd_q.v | chk_dispatch_v_i | chk_poison_isd_i);
    assign issue_fire    = issue_v_i & issue_ready_o;
    assign ex1_go        = isd_q.v & chk_dispatch_v_i & ~chk_poison_isd_i & ~chk_roll_i;

    always_comb begin
        isd_d = isd_q;
        if (chk_roll_i) begin
            isd_d.v = 1'b0;
        end else if (issue_fire) begin
            isd_d.v   = 1'b1;
            isd_d.pc  = issue_pc_i;
            isd_d.rd  = issue_rd_addr_i;
            isd_d.irf = issue_irf_w_v_i;
            isd_d.frf = issue_frf_w_v_i;
        end else if (chk_dispatch_v_i | chk_poison_isd_i) begin
            isd_d.v = 1'b0;
        end
    end

    // Write flags are stored pre-gated so the stage outputs stay pure register reads.
    always_comb begin
        ex_d        = ex_q;
        ex_d[0]     = isd_q;
        ex_d[0].v   = ex1_go;
        ex_d[0].irf = isd_q.irf & ex1_go;
        ex_d[0].frf = isd_q.frf & ex1_go;
        for (int i = 1; i < STAGES; i++) begin
            ex_d[i]     = ex_q[i-1];
            ex_d[i].v   = ex_q[i-1].v & ~chk_poison_ex_i & ~chk_roll_i;
            ex_d[i].irf = ex_q[i-1].irf & ex_d[i].v;
            ex_d[i].frf = ex_q[i-1].frf & ex_d[i].v;
        end
    end

    always_comb begin
        npc_v_d = npc_v_q;
        npc_d   = npc_q;
        if (chk_roll_i) begin
            npc_v_d = 1'b0;
        end else if (ex_q[0].v) begin
            npc_v_d = 1'b1;
            npc_d   = ex1_br_taken_i ? ex1_br_tgt_i : ex_q[0].pc + 64'd4;
        end else if (ex1_go) begin
            npc_v_d = 1'b0;
        end
    end

    // EX3 retires regardless of a concurrent roll.
    assign retire_cnt_d = retire_cnt_q + {31'd0, ex_q[STAGES-1].v};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            isd_q        <= '0;
            ex_q         <= '0;
            npc_v_q      <= 1'b0;
            npc_q        <= '0;
            retire_cnt_q <= '0;
        end else begin
            isd_q        <= isd_d;
            ex_q         <= ex_d;
            npc_v_q      <= npc_v_d;
            npc_q        <= npc_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage_out
        assign stage_v_o[g]             = ex_q[g].v;
        assign stage_rd_addr_o[g*5 +: 5] = ex_q[g].rd;
        assign stage_irf_w_v_o[g]       = ex_q[g].irf;
        assign stage_frf_w_v_o[g]       = ex_q[g].frf;
    end

    assign isd_v_o          = isd_q.v;
    assign isd_pc_o         = isd_q.pc;
    assign isd_rd_addr_o    = isd_q.rd;
    assign expected_npc_v_o = npc_v_q;
    assign expected_npc_o   = npc_q;
    assign retire_cnt_o     = retire_cnt_q;

endmodule

// File: doc/bp_be_calc_status_tracker.md
BP_BE_CALC_STATUS_TRACKER -- requirements
Module: bp_be_calc_status_tracker

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk_i  input  1  rising-edge clock.
REQ-003 reset_i  input  1  asynchronous, active-high reset.
REQ-004 issue_v_i  input  1  an issued instruction is offered.
REQ-005 issue_ready_o  output  1  the offered instruction is accepted this cycle.
REQ-006 issue_pc_i  input  64  PC of the offered instruction.
REQ-007 issue_rd_addr_i  input  5  destination register of the offered instruction.
REQ-008 issue_irf_w_v_i / issue_frf_w_v_i  input  1 each  the instruction writes the integer / FP register file.
REQ-009 chk_dispatch_v_i  input  1  detector allows the ISD instruction to advance.
REQ-010 chk_poison_isd_i  input  1  kill the instruction currently in ISD.
REQ-011 chk_poison_ex_i  input  1  kill the instructions currently in EX1 and EX2.
REQ-012 chk_roll_i  input  1  flush the whole pipe.
REQ-013 ex1_br_taken_i  input  1  EX1 branch resolved taken.
REQ-014 ex1_br_tgt_i  input  64  EX1 branch target.
REQ-015 stage_v_o  output  3  valid bit for EX1, EX2, EX3 (bits 0, 1, 2).
REQ-016 stage_rd_addr_o  output  15  destination register per stage, 5 bits each, EX1 in the low bits.
REQ-017 stage_irf_w_v_o / stage_frf_w_v_o  output  3 each  write flags per stage, gated by the stage valid bit.
REQ-018 isd_v_o  output  1  ISD slot valid.
REQ-019 isd_pc_o  output  64  PC held in ISD.
REQ-020 isd_rd_addr_o  output  5  destination register held in ISD.
REQ-021 expected_npc_v_o  output  1  expected_npc_o is meaningful.
REQ-022 expected_npc_o  output  64  next PC predicted by the resolved path.
REQ-023 retire_cnt_o  output  32  count of instructions that left EX3 while valid.

Function
REQ-024 issue_ready_o SHALL equal ~chk_roll_i & (~isd_v | chk_dispatch_v_i | chk_poison_isd_i).
REQ-025 ISD SHALL load the issue_* fields with isd_v=1 when issue_v_i & issue_ready_o.
REQ-026 ISD SHALL clear isd_v when it dispatches, is poisoned or is rolled, and no new load occurs that cycle.
REQ-027 ISD SHALL otherwise hold its contents.
REQ-028 EX1 SHALL load ISD contents with v=1 when isd_v & chk_dispatch_v_i & ~chk_poison_isd_i & ~chk_roll_i; otherwise EX1 SHALL load a bubble (v=0).
REQ-029 Each cycle EX2<=EX1 and EX3<=EX2 unconditionally, with no stall.
REQ-030 When chk_poison_ex_i=1, the next EX2.v and EX3.v SHALL be 0.
REQ-031 When chk_roll_i=1, all stage valid bits, isd_v and expected_npc_v SHALL be 0 on the next cycle, overriding all other updates.
REQ-032 When EX1.v=1, the block SHALL register expected_npc as ex1_br_taken_i ? ex1_br_tgt_i : EX1.pc+4 (64-bit modulo arithmetic) and set expected_npc_v=1.
REQ-033 expected_npc_v SHALL be cleared when an expected NPC is consumed, i.e. when ISD dispatches and EX1 is not valid.
REQ-034 retire_cnt SHALL increment by 1 on each cycle that EX3.v=1 (poison does not affect EX3).
REQ-035 retire_cnt SHALL wrap from 0xFFFFFFFF to 0.
REQ-036 All outputs except issue_ready_o SHALL come directly from registers, with one-cycle latency from any input.
REQ-037 Simultaneous poison_isd and dispatch: poison SHALL win.
REQ-038 Simultaneous roll with any other input: roll SHALL win, with no retire-count suppression.

Reset
REQ-039 On reset_i assertion, the block SHALL immediately clear all valid bits, expected_npc_v and retire_cnt_o, and SHALL zero all data registers.
REQ-040 issue_ready_o SHALL be 1 during and after reset once chk_roll_i=0.
REQ-041 Reset asserted mid-operation SHALL discard all in-flight instructions, with no retire counted.

Verification
REQ-042 Scenario: issue rd=5, irf_w=1 with dispatch held 1 -> stage_v_o = 001, 010, 100 on cycles +2, +3, +4; retire_cnt_o=1 at +5.
REQ-043 Scenario: ISD valid, chk_dispatch_v_i=0 for 3 cycles -> issue_ready_o=0, ISD holds, EX1 receives bubbles, retire_cnt_o unchanged.
REQ-044 Scenario: EX1 and EX2 valid with chk_poison_ex_i=1 -> next cycle stage_v_o[2:1]=00, and retire_cnt_o does not count them.
REQ-045 Scenario: EX1 pc=0x1000 with br_taken=0 -> expected_npc_o=0x1004; with br_taken=1 and tgt=0x2000 -> 0x2000.
REQ-046 Scenario: chk_roll_i together with issue_v_i and dispatch -> issue_ready_o=0, and next cycle all valid bits are 0.
REQ-047 Scenario: preload retire_cnt_o to 0xFFFFFFFF via a long run, retire one more instruction -> retire_cnt_o=0; async reset mid-run -> outputs zero without a clock edge.
